k2_result_capture: RTL

- Output stage of the K2 processor.
- Watches the processor's `result` bus (the RO register output) and pushes every new value into a small FIFO.
- Presents the FIFO head to a downstream consumer (display or serial driver) over a valid/ready handshake.
- The processor cannot stall, so values arriving while the FIFO is full are dropped and flagged.

---
 rtl/k2_pkg.sv | 21 ++
 rtl/k2_fifo_mem.sv | 40 ++++
 rtl/k2_result_capture.sv | 105 ++++++++++
 3 files changed

// File: rtl/k2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : k2_pkg
//  Description : Shared constants for the K2 result-capture stage.
//                K2_BITS      - processor data width
//                K2_CAP_DEPTH - capture FIFO entries (power of two, >= 2)
//                k2_ptr_width - pointer width for a given FIFO depth
//  Revision    : 1.0 - initial release
// ============================================================================
package k2_pkg;

    localparam int K2_BITS      = 8;
    localparam int K2_CAP_DEPTH = 8;

    // Pointers wrap naturally, so their width is exactly log2(depth).
    function automatic int k2_ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage : k2_pkg
`default_nettype wire

// File: rtl/k2_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : k2_fifo_mem
//  Description : DEPTH x bits storage array with one synchronous write port
//                and one combinational read port. Not reset.
//  Ports       : clk   - clock, rising edge
//                we    - write enable
//                waddr - write address
//                wdata - write data
//                raddr - read address
//                rdata - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module k2_fifo_mem
    import k2_pkg::*;
#(
    parameter int bits  = K2_BITS,
    parameter int DEPTH = K2_CAP_DEPTH,
    parameter int AW    = k2_ptr_width(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [bits-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [bits-1:0] rdata
);

    logic [bits-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : k2_fifo_mem
`default_nettype wire

// File: rtl/k2_result_capture.sv
`default_nettype none
// ============================================================================
//  Module      : k2_result_capture
//  Description : K2 output stage. Captures every change of the processor
//                result bus into a small FIFO and presents the head entry
//                over a valid/ready handshake. Values arriving while the
//                FIFO is full (and not being popped) are dropped and flagged
//                in a sticky overflow bit.
//  Ports       : clk          - clock, rising edge
//                reset        - asynchronous active-low reset
//                result_in    - processor result bus
//                out_ready    - consumer accepts head entry this cycle
//                overflow_clr - synchronous clear of overflow
//                out_data     - FIFO head entry (valid while out_valid)
//                out_valid    - FIFO non-empty
//                count        - occupancy, 0..DEPTH
//                overflow     - sticky: at least one value dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module k2_result_capture
    import k2_pkg::*;
#(
    parameter int bits  = K2_BITS,
    parameter int DEPTH = K2_CAP_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [bits-1:0]          result_in,
    input  logic                     out_ready,
    input  logic                     overflow_clr,
    output logic [bits-1:0]          out_data,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = k2_ptr_width(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_full = CW'(DEPTH);

    logic [bits-1:0] last_q;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic push;
    logic pop;
    logic accept;
    logic drop;

    // A new value is any value differing from the last one observed; the
    // reset value of last_q (0) means a steady 0 is never captured.
    assign push      = (result_in != last_q);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // When full, a simultaneous pop frees the slot being written.
    assign accept    = push & ((count < c_full) | pop);
    assign drop      = push & ~accept;

    k2_fifo_mem #(
        .bits  (bits),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (result_in),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // last_q follows the bus even on a drop so nothing is retried.
            if (push) begin
                last_q <= result_in;
            end
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Set has priority over clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule : k2_result_capture
`default_nettype wire
